// File: rtl/i2c_sensor_burst_seq.sv
// Burst I2C transaction sequencer: address, register pointer, then N write bytes
// or a repeated-start read of N bytes, driving the bit-level I2C master core.
module i2c_sensor_burst_seq #(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 4,
    parameter int BIT_CYC   = 2,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic [6:0]                    sensor_addr,
    input  logic [7:0]                    reg_ptr,
    input  logic [CNT_W-1:0]              byte_count,
    input  logic [MAX_BYTES*DATA_W-1:0]   write_data,
    output logic [MAX_BYTES*DATA_W-1:0]   read_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          master_en,
    output logic                          master_start,
    output logic                          master_stop,
    output logic                          master_mode,
    output logic                          master_nack,
    output logic [6:0]                    slave_addr,
    output logic [7:0]                    write_slave_data,
    input  logic [7:0]                    read_slave_data,
    input  logic                          slave_nack
);

    localparam int PH_W = $clog2(10 * BIT_CYC);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_PTR, S_PTR_ACK, S_WR_BYTE, S_WR_ACK,
        S_RD_ADDR, S_RD_BYTE, S_RD_ACK, S_STOP, S_DONE
    } state_t;

    state_t                        st_q, st_d;
    logic [PH_W-1:0]               cnt_q, cnt_d;
    logic [CNT_W-1:0]              idx_q, idx_d, n_q, n_d, bc_clamp;
    logic                          mode_q, mode_d, err_q, err_d;
    logic                          ph_end, last_byte;
    logic [6:0]                    addr_q, addr_d, saddr_d;
    logic [7:0]                    ptr_q, ptr_d, wbyte_d;
    logic [MAX_BYTES*DATA_W-1:0]   wdata_q, wdata_d, rd_q, rd_d;

    function automatic logic [PH_W-1:0] ph_last(input state_t s);
        case (s)
            S_ADDR, S_RD_ADDR:             return PH_W'(10 * BIT_CYC - 1);
            S_PTR, S_WR_BYTE, S_RD_BYTE:   return PH_W'(8 * BIT_CYC - 1);
            S_PTR_ACK, S_WR_ACK, S_RD_ACK,
            S_STOP:                        return PH_W'(BIT_CYC - 1);
            default:                       return '0;
        endcase
    endfunction

    always_comb begin
        st_d    = st_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        idx_d   = idx_q;
        n_d     = n_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        ph_end    = (cnt_q == '0);
        last_byte = ((idx_q + 1'b1) == n_q);
        bc_clamp  = (byte_count > MAX_N) ? MAX_N : byte_count;

        case (st_q)
            S_IDLE: if (start) begin
                mode_d  = mode;
                addr_d  = sensor_addr;
                ptr_d   = reg_ptr;
                wdata_d = write_data;
                n_d     = (mode && bc_clamp == '0) ? CNT_W'(1) : bc_clamp;
                idx_d   = '0;
                rd_d    = '0;
                err_d   = 1'b0;
                st_d    = S_ADDR;
            end
            S_ADDR: if (ph_end) begin
                if (slave_nack) begin
                    err_d = 1'b1;
                    st_d  = S_STOP;
                end else begin
                    st_d = S_PTR;
                end
            end
            S_PTR: if (ph_end) st_d = S_PTR_ACK;
            S_PTR_ACK: if (ph_end) begin
                if (slave_nack) begin
                    err_d = 1'b1;
                    st_d  = S_STOP;
                end else if (mode_q) begin
                    st_d = S_RD_ADDR;
                end else if (n_q == '0) begin
                    st_d = S_STOP;
                end else begin
                    st_d = S_WR_BYTE;
                end
            end
            S_WR_BYTE: if (ph_end) st_d = S_WR_ACK;
            S_WR_ACK: if (ph_end) begin
                if (slave_nack) begin
                    err_d = 1'b1;
                    st_d  = S_STOP;
                end else if (last_byte) begin
                    st_d = S_STOP;
                end else begin
                    idx_d = idx_q + 1'b1;
                    st_d  = S_WR_BYTE;
                end
            end
            S_RD_ADDR: if (ph_end) begin
                if (slave_nack) begin
                    err_d = 1'b1;
                    st_d  = S_STOP;
                end else begin
                    st_d = S_RD_BYTE;
                end
            end
            S_RD_BYTE: if (ph_end) begin
                for (int unsigned i = 0; i < MAX_BYTES; i++)
                    if (idx_q == CNT_W'(i)) rd_d[i*DATA_W +: DATA_W] = read_slave_data;
                st_d = S_RD_ACK;
            end
            S_RD_ACK: if (ph_end) begin
                if (last_byte) begin
                    st_d = S_STOP;
                end else begin
                    idx_d = idx_q + 1'b1;
                    st_d  = S_RD_BYTE;
                end
            end
            S_STOP: if (ph_end) st_d = S_DONE;
            default: st_d = S_IDLE;
        endcase

        // every state change starts a fresh phase
        if (st_d != st_q) cnt_d = ph_last(st_d);

        wbyte_d = '0;
        if (st_d == S_PTR) begin
            wbyte_d = ptr_d;
        end else if (st_d == S_WR_BYTE) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++)
                if (idx_d == CNT_W'(i)) wbyte_d = wdata_d[i*DATA_W +: DATA_W];
        end
        saddr_d = (st_d == S_ADDR || st_d == S_RD_ADDR) ? addr_d : '0;
    end

    // Outputs are registered from the next-state decode so they track the state register exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q             <= S_IDLE;
            cnt_q            <= '0;
            idx_q            <= '0;
            n_q              <= '0;
            mode_q           <= 1'b0;
            addr_q           <= '0;
            ptr_q            <= '0;
            wdata_q          <= '0;
            rd_q             <= '0;
            err_q            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            master_en        <= 1'b0;
            master_start     <= 1'b0;
            master_stop      <= 1'b1;
            master_mode      <= 1'b0;
            master_nack      <= 1'b0;
            slave_addr       <= '0;
            write_slave_data <= '0;
        end else begin
            st_q             <= st_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            n_q              <= n_d;
            mode_q           <= mode_d;
            addr_q           <= addr_d;
            ptr_q            <= ptr_d;
            wdata_q          <= wdata_d;
            rd_q             <= rd_d;
            err_q            <= err_d;
            busy             <= (st_d != S_IDLE);
            done             <= (st_d == S_DONE);
            master_en        <= !(st_d inside {S_IDLE, S_DONE});
            master_start     <= !(st_d inside {S_IDLE, S_STOP, S_DONE});
            master_stop      <= (st_d inside {S_IDLE, S_STOP, S_DONE});
            master_mode      <= (st_d inside {S_RD_ADDR, S_RD_BYTE, S_RD_ACK});
            master_nack      <= (st_d == S_RD_ACK) && ((idx_d + 1'b1) == n_d);
            slave_addr       <= saddr_d;
            write_slave_data <= wbyte_d;
        end
    end

    assign read_data = rd_q;
    assign error     = err_q;

endmodule

// File: tb/tb_i2c_sensor_burst_seq.sv
// Scoreboard bench: stimulus queues expected transaction results and per-cycle probes,
// a negedge monitor pops and compares them as the sequencer runs.
module tb_i2c_sensor_burst_seq;

    localparam int MAXB  = 4;
    localparam int CW    = 3;
    localparam int RD0   = 59;
    localparam int S_WSD = 0, S_NACK = 1, S_MODE = 2, S_STOP = 3, S_ADDR = 4;

    logic              clock = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
    logic [6:0]        sensor_addr = '0;
    logic [7:0]        reg_ptr = '0;
    logic [CW-1:0]     byte_count = '0;
    logic [MAXB*8-1:0] write_data = '0;
    logic [MAXB*8-1:0] read_data;
    logic              busy, done, error;
    logic              master_en, master_start, master_stop, master_mode, master_nack;
    logic [6:0]        slave_addr;
    logic [7:0]        write_slave_data;
    logic [7:0]        read_slave_data = 8'hA5;
    logic              slave_nack = 1'b0;

    i2c_sensor_burst_seq #(.DATA_W(8), .MAX_BYTES(MAXB), .BIT_CYC(2)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .sensor_addr(sensor_addr), .reg_ptr(reg_ptr), .byte_count(byte_count),
        .write_data(write_data), .read_data(read_data), .busy(busy), .done(done),
        .error(error), .master_en(master_en), .master_start(master_start),
        .master_stop(master_stop), .master_mode(master_mode), .master_nack(master_nack),
        .slave_addr(slave_addr), .write_slave_data(write_slave_data),
        .read_slave_data(read_slave_data), .slave_nack(slave_nack)
    );

    always #5 clock = ~clock;

    typedef struct { int done_cyc; logic err; logic [31:0] rdata; int nack_n; int mode_n; } exp_t;
    typedef struct { int txn; int cyc; int sig; logic [31:0] val; } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    int     checks = 0, errors = 0, tid = 0;
    logic [7:0] rb [0:MAXB-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_probe(input int cyc, input int sig, input logic [31:0] val);
        probe_t p;
        p.txn = tid; p.cyc = cyc; p.sig = sig; p.val = val;
        probe_q.push_back(p);
    endtask

    task automatic push_exp(input int dc, input logic e, input logic [31:0] rd, input int nn, input int mn);
        exp_t x;
        x.done_cyc = dc; x.err = e; x.rdata = rd; x.nack_n = nn; x.mode_n = mn;
        exp_q.push_back(x);
    endtask

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_WSD:   return {24'h0, write_slave_data};
            S_NACK:  return {31'h0, master_nack};
            S_MODE:  return {31'h0, master_mode};
            S_STOP:  return {31'h0, master_stop};
            default: return {25'h0, slave_addr};
        endcase
    endfunction

    // Monitor: cycle 1 is the first cycle busy is seen high.
    int mon_txn = 0, t = 0, nack_n = 0, mode_n = 0;
    bit active = 0;
    always @(negedge clock) begin
        if (reset) begin
            active = 0;
        end else begin
            if (!active && busy) begin
                active = 1; t = 0; nack_n = 0; mode_n = 0;
            end
            if (active) begin
                t++;
                nack_n += int'(master_nack);
                mode_n += int'(master_mode);
                while (probe_q.size() > 0 && probe_q[0].txn == mon_txn && probe_q[0].cyc == t) begin
                    probe_t p;
                    p = probe_q.pop_front();
                    chk($sformatf("probe_t%0d_c%0d_s%0d", p.txn, p.cyc, p.sig), sig_val(p.sig), p.val);
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        chk($sformatf("done_cycle_t%0d", mon_txn), t, x.done_cyc);
                        chk($sformatf("error_t%0d", mon_txn), {31'h0, error}, {31'h0, x.err});
                        chk($sformatf("read_data_t%0d", mon_txn), read_data, x.rdata);
                        chk($sformatf("nack_cycles_t%0d", mon_txn), nack_n, x.nack_n);
                        chk($sformatf("mode_cycles_t%0d", mon_txn), mode_n, x.mode_n);
                    end
                    while (probe_q.size() > 0 && probe_q[0].txn == mon_txn) begin
                        probe_t p;
                        p = probe_q.pop_front();
                        chk($sformatf("probe_unreached_t%0d_c%0d", p.txn, p.cyc), 32'd1, 32'd0);
                    end
                    mon_txn++;
                    active = 0;
                end
            end
        end
    end

    task automatic run_txn(input logic md, input logic [6:0] a, input logic [7:0] p,
                           input logic [CW-1:0] bc, input logic [31:0] wd,
                           input int nack_at, input int start_at);
        int c, w;
        w = 0;
        @(negedge clock);
        while (busy && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        mode = md; sensor_addr = a; reg_ptr = p; byte_count = bc; write_data = wd;
        start = 1'b1;
        @(posedge clock);
        c = 0;
        do begin
            @(negedge clock);
            c++;
            start      = (c == start_at);
            slave_nack = (c == nack_at);
            if (c >= RD0 && ((c - RD0) % 18) < 16 && ((c - RD0) / 18) < MAXB)
                read_slave_data = rb[(c - RD0) / 18];
            else
                read_slave_data = 8'hA5;
        end while (!done && c < 400);
        if (!done) chk("done_timeout", 32'd1, 32'd0);
        start = 1'b0; slave_nack = 1'b0;
        tid++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_master_stop", {31'h0, master_stop}, 32'd1);

        // Reset in the middle of the first WR_BYTE phase.
        mode = 1'b0; sensor_addr = 7'h48; reg_ptr = 8'h1A; byte_count = 3'd2; write_data = 32'hBEEF;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (45) @(negedge clock);
        chk("mid_wr_busy", {31'h0, busy}, 32'd1);
        chk("mid_wr_byte", {24'h0, write_slave_data}, 32'hEF);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst2_outs",
            {22'h0, busy, done, error, master_en, master_start, master_stop, master_mode, master_nack, 2'b0},
            {22'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b0});
        chk("rst2_addr_wsd", {17'h0, slave_addr, write_slave_data}, 32'd0);
        chk("rst2_read_data", read_data, 32'd0);
        @(negedge clock);
        chk("rst2_still_idle", {31'h0, busy}, 32'd0);

        // Write burst n=2.
        push_probe(1, S_ADDR, 32'h48);   push_probe(20, S_ADDR, 32'h48);
        push_probe(21, S_WSD, 32'h1A);   push_probe(21, S_ADDR, 32'h0);
        push_probe(36, S_WSD, 32'h1A);   push_probe(37, S_WSD, 32'h0);
        push_probe(39, S_WSD, 32'hEF);   push_probe(54, S_WSD, 32'hEF);
        push_probe(55, S_WSD, 32'h0);    push_probe(57, S_WSD, 32'hBE);
        push_probe(72, S_WSD, 32'hBE);   push_probe(73, S_WSD, 32'h0);
        push_probe(74, S_STOP, 32'd0);   push_probe(75, S_STOP, 32'd1);
        push_exp(77, 1'b0, 32'h0, 0, 0);
        run_txn(1'b0, 7'h48, 8'h1A, 3'd2, 32'h0000BEEF, -1, -1);

        // Read burst n=3.
        rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
        push_probe(38, S_MODE, 32'd0);   push_probe(39, S_MODE, 32'd1);
        push_probe(39, S_ADDR, 32'h48);  push_probe(75, S_NACK, 32'd0);
        push_probe(110, S_NACK, 32'd0);  push_probe(111, S_NACK, 32'd1);
        push_probe(112, S_NACK, 32'd1);  push_probe(112, S_MODE, 32'd1);
        push_probe(113, S_MODE, 32'd0);  push_probe(113, S_NACK, 32'd0);
        push_exp(115, 1'b0, 32'h00332211, 2, 74);
        run_txn(1'b1, 7'h48, 8'h20, 3'd3, 32'h0, -1, -1);

        // Address NACK: no pointer phase, straight to STOP.
        push_probe(21, S_STOP, 32'd1);   push_probe(21, S_WSD, 32'h0);
        push_probe(22, S_STOP, 32'd1);   push_probe(22, S_WSD, 32'h0);
        push_exp(23, 1'b1, 32'h0, 0, 0);
        run_txn(1'b0, 7'h29, 8'h55, 3'd2, 32'hCAFE, 20, -1);
        @(negedge clock);
        chk("error_sticky", {31'h0, error}, 32'd1);

        // byte_count=7 clamps to 4 write bytes.
        push_probe(75, S_WSD, 32'h33);   push_probe(93, S_WSD, 32'h44);
        push_probe(108, S_WSD, 32'h44);  push_probe(109, S_WSD, 32'h0);
        push_exp(113, 1'b0, 32'h0, 0, 0);
        run_txn(1'b0, 7'h10, 8'h01, 3'd7, 32'h44332211, -1, -1);

        // Read with byte_count=0 reads one byte.
        rb[0] = 8'h77; rb[1] = 8'h88;
        push_exp(79, 1'b0, 32'h00000077, 2, 38);
        run_txn(1'b1, 7'h3F, 8'h02, 3'd0, 32'h0, -1, -1);

        // Pointer-only write, with a start pulse during busy.
        push_probe(37, S_WSD, 32'h0);    push_probe(38, S_STOP, 32'd0);
        push_probe(39, S_STOP, 32'd1);   push_probe(40, S_STOP, 32'd1);
        push_exp(41, 1'b0, 32'h0, 0, 0);
        run_txn(1'b0, 7'h50, 8'h3C, 3'd0, 32'hFFFFFFFF, -1, 10);
        repeat (3) @(negedge clock);
        chk("ptr_only_idle_after", {31'h0, busy}, 32'd0);

        // Read NACK on the repeated-start address.
        rb[0] = 8'h99;
        push_probe(59, S_STOP, 32'd1);   push_probe(59, S_MODE, 32'd0);
        push_exp(61, 1'b1, 32'h0, 0, 20);
        run_txn(1'b1, 7'h48, 8'h04, 3'd2, 32'h0, 58, -1);

        repeat (5) @(negedge clock);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("probe_queue_drained", probe_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
